// File: rtl/even_parity_pkg.sv
// Shared types and sizing helpers for the even-parity serial transmitter.
// Latency: n/a. Backpressure: n/a.
package even_parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    // Bit-index register width; a 1-bit word still needs a 1-bit index.
    function automatic int idx_w(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

    // Serial frame length: the data bits plus the trailing parity bit.
    function automatic int frame_w(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/even_parity_gen.sv
// Even-parity generator: p is the XOR of all data bits.
// Latency: combinational. Backpressure: none.
module even_parity_gen
    import even_parity_pkg::*;
#(
    parameter int DATA_W = 3
) (
    input  logic [DATA_W-1:0] data,
    output logic              p
);

    assign p = ^data;

endmodule

// File: rtl/even_parity_serial_tx.sv
// Serialises a parallel word MSB-first followed by its even-parity bit.
// Latency: first bit one cycle after accept. Backpressure: tx_ready low freezes all outputs.
module even_parity_serial_tx
    import even_parity_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic [CNT_W-1:0]  frames_sent
);

    localparam int IDX_W = idx_w(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LOAD = IDX_W'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nxt;
    logic [IDX_W-1:0]  idx_q;
    logic              par_q;
    logic              par_in;
    logic              in_xfer;

    even_parity_gen #(
        .DATA_W (DATA_W)
    ) u_gen (
        .data (in_data),
        .p    (par_in)
    );

    // The parity slot can hand over to the next word on the edge its bit leaves.
    assign in_ready  = (state == IDLE) || ((state == PAR) && tx_ready);
    assign in_xfer   = in_valid && in_ready;
    assign shift_nxt = shift_q << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            par_q       <= 1'b0;
            tx_bit      <= 1'b0;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
            frames_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        state    <= DATA;
                        shift_q  <= in_data;
                        par_q    <= par_in;
                        idx_q    <= IDX_LOAD;
                        tx_bit   <= in_data[DATA_W-1];
                        tx_valid <= 1'b1;
                        tx_last  <= 1'b0;
                    end
                end
                DATA: begin
                    if (tx_ready) begin
                        if (idx_q == '0) begin
                            state   <= PAR;
                            tx_bit  <= par_q;
                            tx_last <= 1'b1;
                        end else begin
                            shift_q <= shift_nxt;
                            idx_q   <= idx_q - IDX_W'(1);
                            tx_bit  <= shift_nxt[DATA_W-1];
                        end
                    end
                end
                PAR: begin
                    if (tx_ready) begin
                        frames_sent <= frames_sent + CNT_W'(1);
                        if (in_xfer) begin
                            state    <= DATA;
                            shift_q  <= in_data;
                            par_q    <= par_in;
                            idx_q    <= IDX_LOAD;
                            tx_bit   <= in_data[DATA_W-1];
                            tx_valid <= 1'b1;
                            tx_last  <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            tx_bit   <= 1'b0;
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    tx_last  <= 1'b0;
                    tx_bit   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Bench for even_parity_serial_tx: frame table, corner sequences, randomized model check.
module tb_even_parity_serial_tx;

    localparam int DATA_W = 3;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [DATA_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             tx_bit;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_last;
    logic [CNT_W-1:0] frames_sent;

    int n_cmp = 0;
    int n_err = 0;

    even_parity_serial_tx #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx_bit      (tx_bit),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_last     (tx_last),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the block idle; returns at the negedge after the parity bit.
    task automatic send_frame(input logic [DATA_W-1:0] d, output logic [3:0] bits,
                              output logic [3:0] lasts, output logic [3:0] vlds);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bits[3-i]  = tx_bit;
            lasts[3-i] = tx_last;
            vlds[3-i]  = tx_valid;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [3:0]        frame;
    } vec_t;

    // Reference model state for the randomized phase.
    typedef struct {
        logic b;
        logic last;
    } sbit_t;
    sbit_t       exp_q[$];
    logic [CNT_W-1:0] exp_frames;
    logic        stall_prev;
    logic        prev_bit;
    logic        prev_last;
    logic        frame_done;
    logic        accepted;

    function automatic logic ones_parity(input logic [DATA_W-1:0] w);
        int cnt = 0;
        for (int b = 0; b < DATA_W; b++) if (w[b]) cnt++;
        return logic'(cnt % 2);
    endfunction

    task automatic rnd_cycle(input bit drain);
        sbit_t s;
        @(negedge clk);
        check("rnd_valid", tx_valid, (exp_q.size() != 0));
        if (stall_prev) begin
            check("rnd_hold_bit", tx_bit, prev_bit);
            check("rnd_hold_last", tx_last, prev_last);
        end
        if (frame_done) check("rnd_frames", frames_sent, exp_frames);
        if (drain) begin
            tx_ready = 1'b1;
            in_valid = 1'b0;
        end else begin
            tx_ready = ($urandom_range(0, 3) != 0);
            if (accepted || !in_valid) begin
                in_valid = $urandom_range(0, 1) == 1;
                in_data  = DATA_W'($urandom);
            end
        end
        #1;
        frame_done = 1'b0;
        accepted   = 1'b0;
        if (tx_valid && tx_ready && exp_q.size() != 0) begin
            s = exp_q.pop_front();
            check("rnd_bit", tx_bit, s.b);
            check("rnd_last", tx_last, s.last);
            if (s.last) begin
                exp_frames = exp_frames + CNT_W'(1);
                frame_done = 1'b1;
            end
        end
        if (in_valid && in_ready) begin
            accepted = 1'b1;
            for (int b = DATA_W - 1; b >= 0; b--) exp_q.push_back('{in_data[b], 1'b0});
            exp_q.push_back('{ones_parity(in_data), 1'b1});
        end
        stall_prev = tx_valid && !tx_ready;
        prev_bit   = tx_bit;
        prev_last  = tx_last;
    endtask

    initial begin
        vec_t       vecs[8];
        logic [3:0] bits, lasts, vlds;
        logic [7:0] b2b_bits  = 8'b1100_0110;
        logic [7:0] b2b_rdy   = 8'b0001_0001;

        vecs[0] = '{3'b101, 4'b1010};
        vecs[1] = '{3'b111, 4'b1111};
        vecs[2] = '{3'b000, 4'b0000};
        vecs[3] = '{3'b110, 4'b1100};
        vecs[4] = '{3'b011, 4'b0110};
        vecs[5] = '{3'b100, 4'b1001};
        vecs[6] = '{3'b010, 4'b0101};
        vecs[7] = '{3'b001, 4'b0011};

        rst      = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_bit", tx_bit, 1'b0);
        check("rst_tx_last", tx_last, 1'b0);
        check("rst_frames", frames_sent, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_tx_valid", tx_valid, 1'b0);

        // Frame table, each frame also fed to the 4-bit checker (C = XOR of frame).
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, bits, lasts, vlds);
            check($sformatf("tbl_frame_%0d", i), bits, vecs[i].frame);
            check($sformatf("tbl_last_%0d", i), lasts, 4'b0001);
            check($sformatf("tbl_valid_%0d", i), vlds, 4'b1111);
            check($sformatf("tbl_checker_c_%0d", i), ^bits, 1'b0);
            check($sformatf("tbl_in_ready_%0d", i), in_ready, 1'b1);
            check($sformatf("tbl_idle_%0d", i), tx_valid, 1'b0);
        end
        check("tbl_frames_sent", frames_sent, 8);

        // Back-to-back frames with in_valid held.
        in_data  = 3'b110;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("b2b_bit_%0d", i), tx_bit, b2b_bits[7-i]);
            check($sformatf("b2b_valid_%0d", i), tx_valid, 1'b1);
            check($sformatf("b2b_in_ready_%0d", i), in_ready, b2b_rdy[7-i]);
            if (i == 3) in_data = 3'b011;
            if (i == 7) in_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_idle", tx_valid, 1'b0);
        check("b2b_frames", frames_sent, 10);

        // Backpressure on bit 1 of 3'b100, then a stalled parity slot.
        in_data  = 3'b100;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_msb", tx_bit, 1'b1);
        @(negedge clk);
        check("bp_bit1", tx_bit, 1'b0);
        check("bp_idx", dut.idx_q, 1);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_bit_%0d", i), tx_bit, 1'b0);
            check($sformatf("bp_hold_valid_%0d", i), tx_valid, 1'b1);
            check($sformatf("bp_hold_last_%0d", i), tx_last, 1'b0);
            check($sformatf("bp_hold_idx_%0d", i), dut.idx_q, 1);
            check($sformatf("bp_in_ready_%0d", i), in_ready, 1'b0);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check("bp_bit0", tx_bit, 1'b0);
        check("bp_bit0_last", tx_last, 1'b0);
        @(negedge clk);
        check("bp_par", tx_bit, 1'b1);
        check("bp_par_last", tx_last, 1'b1);
        tx_ready = 1'b0;
        #1;
        check("bp_par_in_ready_lo", in_ready, 1'b0);
        @(negedge clk);
        check("bp_par_hold", tx_bit, 1'b1);
        check("bp_par_hold_last", tx_last, 1'b1);
        check("bp_par_frames_hold", frames_sent, 10);
        tx_ready = 1'b1;
        #1;
        check("bp_par_in_ready_hi", in_ready, 1'b1);
        @(negedge clk);
        check("bp_done_idle", tx_valid, 1'b0);
        check("bp_frames", frames_sent, 11);

        // Reset two bits into a frame aborts it.
        in_data  = 3'b101;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_third_bit", tx_bit, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", tx_valid, 1'b0);
        check("abort_last", tx_last, 1'b0);
        check("abort_frames", frames_sent, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_idle", tx_valid, 1'b0);
        send_frame(3'b010, bits, lasts, vlds);
        check("abort_next_frame", bits, 4'b0101);
        check("abort_next_last", lasts, 4'b0001);
        check("abort_next_frames", frames_sent, 1);

        // Randomized traffic against the queue model.
        exp_frames = frames_sent === 8'd1 ? 8'd1 : 8'd1;
        stall_prev = 1'b0;
        prev_bit   = 1'b0;
        prev_last  = 1'b0;
        frame_done = 1'b0;
        accepted   = 1'b0;
        in_valid   = 1'b0;
        for (int c = 0; c < 3000; c++) rnd_cycle(1'b0);
        for (int c = 0; c < 40 && (exp_q.size() != 0 || tx_valid); c++) rnd_cycle(1'b1);
        check("rnd_drained", exp_q.size(), 0);
        check("rnd_final_frames", frames_sent, exp_frames);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
